// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, state encoding and IO-region decode for the instruction cache
package icache_pkg;
  localparam int ICACHE_INDEX_BITS = 7;
  localparam int ICACHE_ADDR_BITS = 17;
  localparam logic [1:0] IO_REGION_HI = 2'b11;
  typedef enum logic {ICACHE_IDLE = 1'b0, ICACHE_MISS = 1'b1} icache_state_e;
  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_REGION_HI;
  endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage, async valid clear, combinational read, synchronous write
module icache_array #(
  parameter int IW = 7,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data
);
  logic [(1<<IW)-1:0] valid;
  logic [TW-1:0] tags [1<<IW];
  logic [31:0] data [1<<IW];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (rdy && we) valid[wr_idx] <= 1'b1;
  // tag/data carry no reset; valid alone qualifies them
  always_ff @(posedge clk)
    if (rdy && we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with single-word miss fill
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_BITS = ICACHE_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_done
);
  localparam int TW = ADDR_BITS - INDEX_BITS - 2;
  icache_state_e state, state_n;
  logic [INDEX_BITS-1:0] req_idx, req_idx_n;
  logic [TW-1:0] req_tag, req_tag_n, rd_tag;
  logic req_io, req_io_n, drop, drop_n, rd_valid, hit, accept, we;
  logic if_valid_n, mem_req_n;
  logic [31:0] if_inst_n, mem_addr_n, rd_data;

  icache_array #(.IW(INDEX_BITS), .TW(TW)) u_array (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_idx(if_addr[INDEX_BITS+1:2]), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
    .we(we), .wr_idx(req_idx), .wr_tag(req_tag), .wr_data(mem_data)
  );

  assign hit = rd_valid && rd_tag == if_addr[ADDR_BITS-1:INDEX_BITS+2] && !is_io(if_addr);
  // blocking on if_valid keeps one response per request and caps hits at one per two cycles
  assign accept = state == ICACHE_IDLE && if_req && !flush && !if_valid;

  always_comb begin
    state_n = state;
    req_idx_n = req_idx;
    req_tag_n = req_tag;
    req_io_n = req_io;
    drop_n = drop;
    if_valid_n = 1'b0;
    if_inst_n = if_inst;
    mem_req_n = mem_req;
    mem_addr_n = mem_addr;
    we = 1'b0;
    if (accept && hit) begin
      if_valid_n = 1'b1;
      if_inst_n = rd_data;
    end else if (accept) begin
      req_idx_n = if_addr[INDEX_BITS+1:2];
      req_tag_n = if_addr[ADDR_BITS-1:INDEX_BITS+2];
      req_io_n = is_io(if_addr);
      mem_req_n = 1'b1;
      mem_addr_n = if_addr & ~32'h3;
      state_n = ICACHE_MISS;
    end else if (state == ICACHE_MISS && mem_done) begin
      we = !req_io;
      if_valid_n = !drop && !flush;
      if_inst_n = (!drop && !flush) ? mem_data : if_inst;
      mem_req_n = 1'b0;
      drop_n = 1'b0;
      state_n = ICACHE_IDLE;
    end else if (state == ICACHE_MISS) begin
      drop_n = drop | flush;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ICACHE_IDLE;
      req_idx <= '0;
      req_tag <= '0;
      req_io <= 1'b0;
      drop <= 1'b0;
      if_valid <= 1'b0;
      if_inst <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
    end else if (rdy) begin
      state <= state_n;
      req_idx <= req_idx_n;
      req_tag <= req_tag_n;
      req_io <= req_io_n;
      drop <= drop_n;
      if_valid <= if_valid_n;
      if_inst <= if_inst_n;
      mem_req <= mem_req_n;
      mem_addr <= mem_addr_n;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: scenario tasks plus randomized fetches against an index/tag/data array model
module tb_icache;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, if_req = 1'b0, flush = 1'b0, mem_done = 1'b0;
  logic [31:0] if_addr = '0, mem_data = '0;
  logic if_valid, mem_req;
  logic [31:0] if_inst, mem_addr;
  int errors = 0, checks = 0;
  bit m_valid [128];
  int m_tag [128];
  logic [31:0] m_data [128];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction
  function automatic int tag_of(input logic [31:0] a);
    return int'((a >> 9) % 256);
  endfunction
  function automatic bit io_of(input logic [31:0] a);
    return ((a >> 16) & 32'd3) == 32'd3;
  endfunction
  function automatic bit model_hit(input logic [31:0] a);
    return !io_of(a) && m_valid[idx_of(a)] && m_tag[idx_of(a)] == tag_of(a);
  endfunction

  // fk: cycle of a flush pulse counted from the first MISS cycle (lat means alongside mem_done), -1 for none
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat, input int fk);
    bit h, dropped;
    logic [31:0] exp_inst;
    h = model_hit(a);
    exp_inst = m_data[idx_of(a)];
    if_req = 1'b1;
    if_addr = a;
    step;
    checks++;
    if (h) begin
      if (if_valid !== 1'b1 || if_inst !== exp_inst || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hit addr=%h: if_valid=%b if_inst=%h mem_req=%b, required 1 %h 0", a, if_valid, if_inst, mem_req, exp_inst);
      end
    end else begin
      if (mem_req !== 1'b1 || mem_addr !== (a & ~32'h3) || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL miss_req addr=%h: mem_req=%b mem_addr=%h if_valid=%b, required 1 %h 0", a, mem_req, mem_addr, if_valid, a & ~32'h3);
      end
      dropped = fk >= 0 && fk <= lat;
      for (int c = 0; c < lat; c++) begin
        flush = (c == fk);
        if_addr = $urandom;
        step;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== (a & ~32'h3) || if_valid !== 1'b0) begin
          errors++;
          $display("FAIL miss_wait addr=%h: mem_req=%b mem_addr=%h if_valid=%b, required 1 %h 0", a, mem_req, mem_addr, if_valid, a & ~32'h3);
        end
      end
      flush = (fk == lat);
      mem_done = 1'b1;
      mem_data = d;
      step;
      mem_done = 1'b0;
      flush = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || if_valid !== (dropped ? 1'b0 : 1'b1) || (!dropped && if_inst !== d)) begin
        errors++;
        $display("FAIL fill addr=%h: mem_req=%b if_valid=%b if_inst=%h, required 0 %b %h", a, mem_req, if_valid, if_inst, !dropped, d);
      end
      if (!io_of(a)) begin
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)] = tag_of(a);
        m_data[idx_of(a)] = d;
      end
    end
    if_req = 1'b0;
    step;
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end addr=%h: if_valid=%b mem_req=%b, required 0 0", a, if_valid, mem_req);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (if_valid !== 1'b0 || if_inst !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset: if_valid=%b if_inst=%h mem_req=%b mem_addr=%h, required all zero", if_valid, if_inst, mem_req, mem_addr);
    end
    step;
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_cold_and_hit;
    fetch(32'h4, 32'h00100093, 5, -1);
    fetch(32'h4, 32'h0, 1, -1);
  endtask

  task automatic test_conflict;
    fetch(32'h204, 32'h11112222, 2, -1);
    fetch(32'h4, 32'h00100093, 1, -1);
    fetch(32'h4, 32'h0, 1, -1);
  endtask

  task automatic test_flush;
    fetch(32'h8, 32'hDEADBEEF, 4, 1);
    fetch(32'h8, 32'h0, 1, -1);
    fetch(32'hC, 32'h0C0C0C0C, 2, 2);
    fetch(32'hC, 32'h0, 1, -1);
    if_req = 1'b1;
    if_addr = 32'h40;
    flush = 1'b1;
    step;
    flush = 1'b0;
    if_req = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: mem_req=%b if_valid=%b, required 0 0", mem_req, if_valid);
    end
    step;
  endtask

  task automatic test_io;
    fetch(32'h00030000, 32'hA5A5A5A5, 1, -1);
    fetch(32'h00030000, 32'h5A5A5A5A, 1, -1);
    fetch(32'h00010000, 32'h01010101, 1, -1);
  endtask

  task automatic test_rdy;
    if_req = 1'b1;
    if_addr = 32'h4;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if (if_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdy_hold cycle %0d: if_valid=%b, required 0", c, if_valid);
      end
    end
    rdy = 1'b1;
    step;
    if_req = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h00100093) begin
      errors++;
      $display("FAIL rdy_release: if_valid=%b if_inst=%h, required 1 00100093", if_valid, if_inst);
    end
    step;
  endtask

  task automatic test_reset_mid_miss;
    if_req = 1'b1;
    if_addr = 32'h100;
    step;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: mem_req=%b, required 1", mem_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: mem_req=%b mem_addr=%h, required 0 00000000", mem_req, mem_addr);
    end
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    if_req = 1'b0;
    step;
    rst = 1'b0;
    step;
    fetch(32'h4, 32'h00200113, 2, -1);
    fetch(32'h4, 32'h0, 1, -1);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int lat, fk;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h00030000;
      if ($urandom_range(0, 3) == 0) a = a | 32'h80000000;
      lat = int'($urandom_range(0, 4));
      fk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat)) : -1;
      fetch(a, $urandom, lat, fk);
    end
  endtask

  initial begin
    test_reset;
    test_cold_and_hit;
    test_conflict;
    test_flush;
    test_io;
    test_rdy;
    test_reset_mid_miss;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between if_stage and the memory controller.
- Serves 32-bit instruction fetches:
  - hits return in 1 cycle;
  - misses issue one word request to the memory controller, fill the line, then respond.
- Removes the multi-cycle byte fetch from the common path and cuts stallreq_if pressure.

Parameters:
- INDEX_BITS, 7, line index width (2^INDEX_BITS one-word lines).
- ADDR_BITS, 17, significant address bits; tag = addr[ADDR_BITS-1 : INDEX_BITS+2].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rdy  in  1  chip enable; low freezes all state.
- if_req  in  1  fetch request; held by if_stage until if_valid.
- if_addr  in  32  fetch address; bits [1:0] ignored.
- flush  in  1  branch redirect; cancels the pending response.
- if_valid  out  1  one-cycle pulse, instruction valid.
- if_inst  out  32  fetched instruction.
- mem_req  out  1  word read request to memory controller (level).
- mem_addr  out  32  word-aligned request address.
- mem_data  in  32  assembled word from memory controller.
- mem_done  in  1  one-cycle pulse, mem_data valid.

Behaviour:
- Reset (async, rst=1):
  - all valid bits cleared;
  - state=IDLE;
  - if_valid=0, if_inst=0, mem_req=0, mem_addr=0;
  - drop flag=0.
  - Tag/data arrays are not reset.
- rdy=0: no register or array changes; outputs hold. mem_done arriving while rdy=0 is not expected (the memory controller is frozen too).
- Lookup is combinational on if_addr: hit = valid[idx] && tag[idx]==if_addr tag field && !io. io = if_addr[17:16]==2'b11.
- IDLE:
  - if_req && hit && !flush: next cycle if_valid=1, if_inst=data[idx]; stay IDLE.
  - if_req && !hit && !flush:
    - latch the address into req_addr;
    - next cycle mem_req=1, mem_addr={if_addr[31:2],2'b00};
    - go to MISS.
  - flush: no response, no request.
- MISS:
  - mem_req held high, mem_addr stable; if_addr changes are ignored.
  - flush=1: set drop flag; the request is NOT cancelled.
  - On mem_done:
    - mem_req=0 next cycle;
    - if req_addr is not io, write data/tag and set valid[idx];
    - if drop=0 and flush=0, next cycle if_valid=1, if_inst=mem_data;
    - clear drop; go to IDLE.
- if_valid is high for exactly one cycle per accepted request. A new request is not accepted in the same cycle if_valid is high. Hit throughput is one instruction every 2 cycles.
- flush and mem_done in the same cycle: the line is filled, no if_valid.
- IO addresses are never cached: always MISS path, no array write.
- Index = addr[INDEX_BITS+1:2]. Addresses above ADDR_BITS alias by design.
- No self-modifying-code coherence; stores do not invalidate lines.

Decomposition:
- Shared defines header (already included by cpu): `AddrLen, `InstLen.
- New defines:
  - `ICacheIdle / `ICacheMiss state encodings (1 bit);
  - `IoRegionHi 2'b11.
- One natural sub-module: icache_array. It holds the valid/tag/data storage, with an async valid clear, a combinational read port and a synchronous write port. icache holds the FSM.

Test Plan:
- Cold miss:
  - Stimulus: reset, if_req at 0x00000004, mem_done after 5 cycles with 0x00100093.
  - Required response: mem_req=1 with mem_addr=0x4; if_valid pulse with if_inst=0x00100093 one cycle after mem_done; mem_req=0 afterwards.
- Hit after fill:
  - Stimulus: re-request 0x4 in IDLE.
  - Required response: no mem_req; if_valid with 0x00100093 on the next cycle.
- Conflict eviction (INDEX_BITS=7):
  - Stimulus: fill 0x0004, then fetch 0x0204, then 0x0004.
  - Required response: each fetch misses and raises mem_req.
- Flush during miss:
  - Stimulus: flush pulse 2 cycles after the miss starts; mem_done with 0xDEADBEEF.
  - Required response: no if_valid; a subsequent request to the same address hits and returns 0xDEADBEEF.
- IO bypass:
  - Stimulus: fetch 0x00030000 twice.
  - Required response: both raise mem_req; no array write.
- rdy low / reset mid-miss:
  - rdy=0 for 3 cycles during a hit cycle: if_valid is delayed by exactly 3 cycles with unchanged data.
  - rst asserted in MISS: mem_req drops immediately (async); after release, address 0x4 misses again.
